// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types, state encoding and key helper for the ARC4 encrypt engine
package arc4_pkg;
  localparam int KEYLEN = 3;
  typedef logic [7:0] byte_t;
  typedef enum logic [4:0] {
    IDLE, INIT,
    KRDI, KWI, KCI, KWJ, KCJ, KWRJ,
    PRD, PWT, PCP,
    G1, G2, G3, G4, G5, G6, G7, G8, G9,
    DONE
  } state_t;
  function automatic byte_t key_byte(input logic [23:0] key, input logic [1:0] idx);
    return (idx == 2'd0) ? key[23:16] : (idx == 2'd1) ? key[15:8] : key[7:0];
  endfunction
endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// s_mem: 256x8 single-port RAM, synchronous read with read-before-write on a shared address
module s_mem
  import arc4_pkg::*;
(
  input  byte_t address,
  input  logic  clock,
  input  byte_t data,
  input  logic  wren,
  output byte_t q
);
  byte_t mem [256];
  always_ff @(posedge clock) begin
    if (wren) mem[address] <= data;
    q <= mem[address];
  end
endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: ARC4 init/KSA/PRGA engine writing a length-prefixed ciphertext image
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);
  state_t state, state_n;
  byte_t i, j, n, si, sj, pad, ptb, s_addr, s_data, s_q, j_n;
  logic [8:0] k;
  logic [23:0] key_r;
  logic [1:0] kidx;
  logic s_wren;

  s_mem u_s_mem (.address(s_addr), .clock(clk), .data(s_data), .wren(s_wren), .q(s_q));

  // key byte only contributes during KSA; PRGA reuses the same adder
  assign j_n = j + s_q + ((state == KCI) ? key_byte(key_r, kidx) : 8'd0);

  assign ct_wren   = (state == PCP) || (state == G9);
  assign ct_addr   = (state == G9) ? k[7:0] : 8'd0;
  assign ct_wrdata = (state == PCP) ? pt_rddata : (state == G9) ? (pad ^ ptb) : 8'd0;
  assign pt_addr   = ((state == G6) || (state == G7)) ? k[7:0] : 8'd0;

  always_comb begin
    state_n = state;
    s_addr  = i;
    s_data  = 8'd0;
    s_wren  = 1'b0;
    case (state)
      IDLE: state_n = en ? INIT : IDLE;
      INIT: begin
        s_data  = i;
        s_wren  = 1'b1;
        state_n = (i == 8'hff) ? KRDI : INIT;
      end
      KRDI: state_n = KWI;
      KWI:  state_n = KCI;
      KCI: begin
        s_addr  = j_n;
        state_n = KWJ;
      end
      KWJ: begin
        s_addr  = j;
        state_n = KCJ;
      end
      KCJ: begin
        s_data  = s_q;
        s_wren  = 1'b1;
        state_n = KWRJ;
      end
      KWRJ: begin
        s_addr  = j;
        s_data  = si;
        s_wren  = 1'b1;
        state_n = (i == 8'hff) ? PRD : KRDI;
      end
      PRD: state_n = PWT;
      PWT: state_n = PCP;
      PCP: state_n = (pt_rddata == 8'd0) ? DONE : G1;
      G1: begin
        s_addr  = i + 8'd1;
        state_n = G2;
      end
      G2: state_n = G3;
      G3: begin
        s_addr  = j_n;
        state_n = G4;
      end
      G4: begin
        s_addr  = j;
        state_n = G5;
      end
      G5: begin
        s_data  = s_q;
        s_wren  = 1'b1;
        state_n = G6;
      end
      G6: begin
        s_addr  = j;
        s_data  = si;
        s_wren  = 1'b1;
        state_n = G7;
      end
      // pad read follows the swap writes, so it sees the updated state
      G7: begin
        s_addr  = si + sj;
        state_n = G8;
      end
      G8: state_n = G9;
      G9: state_n = (k == {1'b0, n}) ? DONE : G1;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rdy   <= 1'b1;
      i     <= 8'd0;
      j     <= 8'd0;
      k     <= 9'd0;
      n     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      pad   <= 8'd0;
      ptb   <= 8'd0;
      key_r <= 24'd0;
      kidx  <= 2'd0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (en) begin
          rdy   <= 1'b0;
          key_r <= key;
          i     <= 8'd0;
        end
        INIT: begin
          i    <= i + 8'd1;
          j    <= 8'd0;
          kidx <= 2'd0;
        end
        KCI: begin
          si <= s_q;
          j  <= j_n;
        end
        KWRJ: begin
          i    <= i + 8'd1;
          kidx <= (kidx == 2'(KEYLEN - 1)) ? 2'd0 : kidx + 2'd1;
        end
        PCP: begin
          n <= pt_rddata;
          i <= 8'd0;
          j <= 8'd0;
          k <= 9'd1;
        end
        G1: i <= i + 8'd1;
        G3: begin
          si <= s_q;
          j  <= j_n;
        end
        G5: sj <= s_q;
        G8: begin
          pad <= s_q;
          ptb <= pt_rddata;
        end
        G9: k <= k + 9'd1;
        DONE: rdy <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: scoreboard bench comparing ct writes and rdy timing against a software ARC4 model
module tb_arc4_encrypt;
  logic clk = 0, reset = 1, en = 0;
  logic rdy, ct_wren;
  logic [23:0] key = 24'd0;
  logic [7:0] pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  typedef struct {int addr; int data; int dt;} wr_t;
  wr_t sb[$];
  wr_t e;
  int lq[$];
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, accepts = 0, last_gap = 0;
  logic prev_rdy = 1'b1;

  arc4_encrypt dut (
    .clk(clk), .reset(reset), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    pt_rddata <= pt_mem[pt_addr];
    if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
  end

  task automatic check(string tag, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic expect_run(logic [23:0] kk, int n);
    int s[256];
    int kb[3];
    int i, j, t;
    kb[0] = int'(kk[23:16]);
    kb[1] = int'(kk[15:8]);
    kb[2] = int'(kk[7:0]);
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + kb[x % 3]) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    sb.push_back('{0, n, 1795});
    i = 0;
    j = 0;
    for (int q = 1; q <= n; q++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      sb.push_back('{q, int'(pt_mem[q]) ^ s[(s[i] + s[j]) % 256], 1795 + 9 * q});
    end
    lq.push_back(1796 + 9 * n);
  endtask

  always @(negedge clk) begin
    if (reset) prev_rdy = 1'b1;
    else begin
      if (rdy && !prev_rdy) begin
        if (lq.size() == 0) check("unexp_rdy", cyc - acc_cyc, -1);
        else check("rdy_latency", cyc - acc_cyc, lq.pop_front());
      end
      if (ct_wren) begin
        if (sb.size() == 0) check("unexp_write", int'(ct_addr), -1);
        else begin
          e = sb.pop_front();
          check("ct_addr", int'(ct_addr), e.addr);
          check("ct_data", int'(ct_wrdata), e.data);
          check("ct_time", cyc + 1 - acc_cyc, e.dt);
        end
      end
      if (rdy && en) begin
        last_gap = cyc + 1 - acc_cyc;
        acc_cyc  = cyc + 1;
        accepts++;
      end
      prev_rdy = rdy;
    end
  end

  task automatic start(logic [23:0] kk);
    @(posedge clk);
    #2 key = kk;
    en = 1'b1;
    @(posedge clk);
    #2 en = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int c = 0;
    while ((sb.size() != 0 || lq.size() != 0 || !rdy) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) check("timeout", sb.size() + lq.size(), 0);
    sb.delete();
    lq.delete();
  endtask

  initial begin
    int a0, c;
    for (int x = 0; x < 256; x++) begin
      pt_mem[x] = 8'd0;
      ct_mem[x] = 8'haa;
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_rdy", int'(rdy), 1);
    check("rst_wren", int'(ct_wren), 0);
    check("rst_pt_addr", int'(pt_addr), 0);
    check("rst_ct_addr", int'(ct_addr), 0);
    check("rst_ct_data", int'(ct_wrdata), 0);

    pt_mem[0] = 8'd3;
    start(24'h123456);
    repeat (898) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("abort_rdy", int'(rdy), 1);
    check("abort_wren", int'(ct_wren), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    pt_mem[0] = 8'd0;
    expect_run(24'h000000, 0);
    start(24'h000000);
    wait_idle(6000);
    check("ct0_n0", int'(ct_mem[0]), 0);

    pt_mem[0] = 8'd5;
    pt_mem[1] = "H"; pt_mem[2] = "e"; pt_mem[3] = "l"; pt_mem[4] = "l"; pt_mem[5] = "o";
    expect_run(24'h1E4600, 5);
    start(24'h1E4600);
    wait_idle(6000);
    check("ct0_hello", int'(ct_mem[0]), 5);

    for (int x = 0; x < 256; x++) pt_mem[x] = 8'(x);
    pt_mem[0] = 8'd255;
    expect_run(24'hFFFFFF, 255);
    start(24'hFFFFFF);
    wait_idle(8000);
    check("ct0_n255", int'(ct_mem[0]), 255);

    pt_mem[0] = 8'd2;
    expect_run(24'hA5A5A5, 2);
    expect_run(24'hA5A5A5, 2);
    a0 = accepts;
    c = 0;
    @(posedge clk);
    #2 key = 24'hA5A5A5;
    en = 1'b1;
    while (accepts < a0 + 2 && c < 5000) begin
      @(posedge clk);
      #2 c++;
    end
    en = 1'b0;
    check("en_hold_gap", last_gap, 1796 + 18 + 1);
    wait_idle(4000);
    repeat (20) @(posedge clk);
    check("en_hold_runs", accepts - a0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
